mole_game_ctrl: RTL and testbench
=================================

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, clocks per game tick (1 ms at 100 MHz).
REQ-002 Parameter MOLE_TICKS, default 800, ticks a mole stays up before counting as missed.
REQ-003 Parameter GAME_TICKS, default 30000, game length in ticks, at most 65535.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  debounced, clk-synchronous level; only its rising edge acts.
REQ-007 key  input  8  debounced, clk-synchronous levels, bit i = hole i; only rising edges act.
REQ-008 mole_oh  output  8  one-hot visible mole, all zero when none is visible.
REQ-009 game_state  output  2  2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER.
REQ-010 score  output  8  hits in the current or last game, saturating at 255.
REQ-011 time_left  output  16  remaining game ticks.
REQ-012 hit_pulse, miss_pulse  output  1 each  single-cycle event strobes.

Function
REQ-013 Edge detect: start_rise = start & ~start_q; key_rise = key & ~key_q; start_q and key_q are registered every clock in all states.
REQ-014 Tick counter: counts 0..TICK_DIV-1 only in PLAY and is cleared on entry to PLAY; tick is asserted for the cycle in which the count equals TICK_DIV-1.
REQ-015 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; it advances every clock in all states and never reaches zero.
REQ-016 Spawn position: p = lfsr[2:0]; if p equals the previous mole index, use p+1 mod 8; the mole age counter is cleared on every spawn.
REQ-017 IDLE -> PLAY on start_rise, with the following values one clock later:
- score = 0
- time_left = GAME_TICKS
- mole_oh = one spawned mole
REQ-018 PLAY, hit (key_rise bit set where mole_oh is set):
- score increments, holding at 255
- hit_pulse = 1 for one cycle
- mole_oh = 0 on the next clock
- a new mole spawns at the next tick
REQ-019 PLAY, wrong key (key_rise bit set where mole_oh is clear, including while no mole is up): miss_pulse = 1 for one cycle; score is unchanged.
REQ-020 PLAY, timeout (tick while age = MOLE_TICKS-1 and a mole is up): miss_pulse = 1, and the mole respawns at a new position on the same clock.
REQ-021 Simultaneous events:
- A correct and a wrong key in the same cycle assert both hit_pulse and miss_pulse.
- A hit in the same cycle as a timeout counts as a hit only; no miss_pulse.
REQ-022 time_left decrements by 1 on each tick in PLAY. On the tick where time_left = 1:
- time_left becomes 0
- game_state becomes OVER
- mole_oh becomes 0
- a hit on that same cycle still scores
REQ-023 start_rise in PLAY is ignored.
REQ-024 OVER: score holds, and key edges produce no pulses; start_rise starts a new game exactly as REQ-017.
REQ-025 Outputs are registered, and an event sampled at clock edge N is visible after edge N.

Reset
REQ-026 While rst = 1, the following hold:
- game_state = IDLE
- mole_oh = 0
- score = 0
- time_left = 0
- hit_pulse = miss_pulse = 0
- tick counter and age = 0
- lfsr = 16'hACE1
- start_q = 1 and key_q = 8'hFF, so levels held through reset are not taken as edges
REQ-027 Reset asserted mid-game aborts the game immediately; after release the block waits in IDLE for a new start_rise.

Verification (TICK_DIV=4, MOLE_TICKS=3, GAME_TICKS=20)
REQ-028 Release rst, pulse start -> the cycle after the edge shows game_state = 01, score = 0, time_left = 20, mole_oh one-hot.
REQ-029 Raise the key bit matching mole_oh -> next cycle hit_pulse = 1 and score = 1; mole_oh = 0 until the next tick, then a new one-hot value at a different index.
REQ-030 Press no keys -> every 3 ticks (12 clocks) miss_pulse = 1 and mole_oh changes index; score stays 0.
REQ-031 key = 8'hFF rising edge with a mole up -> hit_pulse = 1 and miss_pulse = 1 in the same cycle; score increments by 1; holding key high gives no further events.
REQ-032 Run 20 ticks (80 clocks) -> game_state = 10, time_left = 0, mole_oh = 0, score held; pulse start -> PLAY with score = 0 and time_left = 20.
REQ-033 Assert rst mid-PLAY with start and key held high -> IDLE with all outputs zero; after release no game starts until start goes low and then high.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// -----------------------------------------------------------------------------
// mole_game_ctrl
//
// Whack-a-mole game controller. One mole at a time pops up in one of eight
// holes; the player hits it by pressing the matching key before it times out.
// A game lasts a fixed number of ticks, after which the block parks in OVER
// with the final score until the next start.
//
// Parameters
//   TICK_DIV    clocks per game tick
//   MOLE_TICKS  ticks a mole stays up before it counts as missed
//   GAME_TICKS  game length in ticks (at most 65535)
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   start       synchronous level; only its rising edge starts a game
//   key[7:0]    synchronous levels, bit i = hole i; only rising edges act
//   mole_oh     one-hot visible mole, zero when none is up
//   game_state  2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER (also the FSM state)
//   score       hits in the current or last game, saturating at 255
//   time_left   remaining game ticks
//   hit_pulse   one-cycle strobe for a correct key
//   miss_pulse  one-cycle strobe for a wrong key or a timed-out mole
//
// All outputs are registered: an event sampled at edge N shows after edge N.
// There is no handshake on this block; inputs are plain levels that are
// edge-detected internally.
// -----------------------------------------------------------------------------
module mole_game_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int MOLE_TICKS = 800,
  parameter int GAME_TICKS = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] key,
  output logic [7:0] mole_oh,
  output logic [1:0] game_state,
  output logic [7:0] score,
  output logic [15:0] time_left,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(MOLE_TICKS - 1);
  localparam logic [AW-1:0] AGE_ONE  = AW'(1);
  localparam logic [15:0]   GAME_LEN = 16'(GAME_TICKS);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  // Registered copies of the inputs for edge detection. They reset high so
  // that a level held through reset is not mistaken for a press.
  logic          start_q;
  logic [7:0]    key_q;

  logic [15:0]   lfsr;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] age;
  logic [2:0]    last_idx;

  logic          start_rise;
  logic [7:0]    key_rise;
  logic [15:0]   lfsr_next;
  logic [2:0]    spawn_idx;
  logic [7:0]    spawn_oh;
  logic          in_play;
  logic          tick;
  logic          mole_up;
  logic          hit;
  logic          wrong;
  logic          game_end;
  logic          timeout;
  logic          spawn_in_play;

  always_comb begin
    start_rise = start & ~start_q;
    key_rise   = key & ~key_q;

    // Fibonacci LFSR, taps 16,14,13,11. Shifting left keeps the seed's
    // nonzero content, so it never locks up at zero.
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Never spawn twice in the same hole: bump to the next hole on a repeat.
    spawn_idx = (lfsr[2:0] == last_idx) ? lfsr[2:0] + 3'd1 : lfsr[2:0];
    spawn_oh  = 8'b0000_0001 << spawn_idx;

    in_play  = (game_state == ST_PLAY);
    tick     = in_play && (tick_cnt == TICK_MAX);
    mole_up  = |mole_oh;

    hit      = in_play && |(key_rise & mole_oh);
    wrong    = in_play && |(key_rise & ~mole_oh);
    game_end = tick && (time_left == 16'd1);

    // A hit on the timeout tick wins; the mole is then simply gone.
    timeout  = tick && mole_up && (age == AGE_MAX) && !hit;

    // In play a new mole appears on a tick when the hole is empty (after a
    // hit) or the current one expired, but never on the final tick.
    spawn_in_play = tick && !game_end && !hit && (!mole_up || timeout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_state <= ST_IDLE;
      mole_oh    <= 8'h00;
      score      <= 8'h00;
      time_left  <= 16'h0000;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      tick_cnt   <= '0;
      age        <= '0;
      lfsr       <= LFSR_SEED;
      last_idx   <= 3'd0;
      start_q    <= 1'b1;
      key_q      <= 8'hFF;
    end else begin
      lfsr       <= lfsr_next;
      start_q    <= start;
      key_q      <= key;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      case (game_state)
        ST_PLAY: begin
          tick_cnt   <= tick ? '0 : tick_cnt + TICK_ONE;
          hit_pulse  <= hit;
          miss_pulse <= wrong | timeout;

          if (hit && (score != 8'hFF)) begin
            score <= score + 8'd1;
          end

          if (tick) begin
            time_left <= time_left - 16'd1;
          end

          if (game_end) begin
            game_state <= ST_OVER;
            mole_oh    <= 8'h00;
          end else if (spawn_in_play) begin
            mole_oh  <= spawn_oh;
            last_idx <= spawn_idx;
            age      <= '0;
          end else if (hit) begin
            mole_oh <= 8'h00;
          end else if (tick && mole_up) begin
            age <= age + AGE_ONE;
          end
        end

        // IDLE and OVER behave alike: wait for a start edge, keep the score.
        default: begin
          if (start_rise) begin
            game_state <= ST_PLAY;
            score      <= 8'h00;
            time_left  <= GAME_LEN;
            tick_cnt   <= '0;
            age        <= '0;
            mole_oh    <= spawn_oh;
            last_idx   <= spawn_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mole_game_ctrl
//
// Directed bench for mole_game_ctrl with TICK_DIV=4, MOLE_TICKS=3,
// GAME_TICKS=20. A behavioural game model (tick number, spawn tick, hole
// index) predicts the outputs each clock and pushes them to exp_q; a compare
// process checks every cycle. Directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_mole_game_ctrl;

  localparam int TD = 4;
  localparam int MT = 3;
  localparam int GT = 20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  key;
  logic [7:0]  mole_oh;
  logic [1:0]  game_state;
  logic [7:0]  score;
  logic [15:0] time_left;
  logic        hit_pulse;
  logic        miss_pulse;

  always #5 clk = ~clk;

  mole_game_ctrl #(
    .TICK_DIV  (TD),
    .MOLE_TICKS(MT),
    .GAME_TICKS(GT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .mole_oh   (mole_oh),
    .game_state(game_state),
    .score     (score),
    .time_left (time_left),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game seen as: start time, count of clocks in play, tick number, the tick
  // at which the current mole appeared, and which hole it is in.
  int          m_state;       // 0 idle, 1 play, 2 over
  int          m_mole;        // hole index, -1 when no mole
  int          m_last;
  int          m_score;
  int          m_time;
  int          m_cyc;
  int          m_ticks;
  int          m_spawn_tick;
  logic [15:0] m_lfsr;
  logic        m_sq;
  logic [7:0]  m_kq;
  logic        m_hit;
  logic        m_miss;

  logic [35:0] exp_q[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [7:0] hole_bits(input int idx);
    return (idx >= 0) ? 8'(32'd1 << idx) : 8'h00;
  endfunction

  function automatic logic [35:0] exp_vec();
    return {2'(m_state), hole_bits(m_mole), 8'(m_score), 16'(m_time), m_hit, m_miss};
  endfunction

  task automatic model_reset();
    m_state = 0; m_mole = -1; m_last = 0; m_score = 0; m_time = 0;
    m_cyc = 0; m_ticks = 0; m_spawn_tick = 0; m_lfsr = 16'hACE1;
    m_sq = 1'b1; m_kq = 8'hFF; m_hit = 1'b0; m_miss = 1'b0;
  endtask

  task automatic spawn();
    int p;
    p = int'(m_lfsr[2:0]);
    if (p == m_last) p = (p + 1) % 8;
    m_mole = p;
    m_last = p;
    m_spawn_tick = m_ticks;
  endtask

  task automatic model_step();
    logic       sr;
    logic [7:0] kr;
    logic [7:0] mb;
    logic       expired;
    sr = start & ~m_sq;
    kr = key & ~m_kq;
    m_sq = start;
    m_kq = key;
    m_hit = 1'b0;
    m_miss = 1'b0;
    if (m_state != 1) begin
      if (sr) begin
        m_state = 1; m_score = 0; m_time = GT; m_cyc = 0; m_ticks = 0;
        spawn();
      end
    end else begin
      mb = hole_bits(m_mole);
      m_hit  = |(kr & mb);
      m_miss = |(kr & ~mb);
      if (m_hit) begin
        if (m_score < 255) m_score++;
        m_mole = -1;
      end
      m_cyc++;
      if (m_cyc % TD == 0) begin
        m_ticks++;
        m_time = GT - m_ticks;
        expired = !m_hit && (m_mole >= 0) && (m_ticks - m_spawn_tick == MT);
        if (expired) m_miss = 1'b1;
        if (m_ticks == GT) begin
          m_state = 2;
          m_mole = -1;
        end else if (!m_hit && (m_mole < 0 || expired)) begin
          spawn();
        end
      end
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(exp_vec());
    end else begin
      model_step();
      exp_q.push_back(exp_vec());
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [35:0] cmp_e;

  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 (t=%0t)", $time);
    end else begin
      cmp_e = exp_q.pop_front();
      chk("game_state", 32'(game_state), 32'(cmp_e[35:34]));
      chk("mole_oh",    32'(mole_oh),    32'(cmp_e[33:26]));
      chk("score",      32'(score),      32'(cmp_e[25:18]));
      chk("time_left",  32'(time_left),  32'(cmp_e[17:2]));
      chk("hit_pulse",  32'(hit_pulse),  32'(cmp_e[1]));
      chk("miss_pulse", 32'(miss_pulse), 32'(cmp_e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a falling edge, well clear of both edges.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // ---------------- directed stimulus ----------------
  int   old_idx;
  int   gap;
  logic found;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key = 8'h00;
    cycles(3);
    chk("reset_state", 32'(game_state), 0);
    chk("reset_mole",  32'(mole_oh), 0);
    chk("reset_score", 32'(score), 0);
    chk("reset_time",  32'(time_left), 0);

    // Start a game.
    rst = 1'b0;
    cycles(2);
    start = 1'b1;
    cyc();
    chk("start_state", 32'(game_state), 1);
    chk("start_score", 32'(score), 0);
    chk("start_time",  32'(time_left), 20);
    chk("start_onehot", 32'($countones(mole_oh)), 1);
    start = 1'b0;

    // Hit the visible mole.
    old_idx = m_mole;
    key = hole_bits(m_mole);
    cyc();
    chk("hit_pulse_lit", 32'(hit_pulse), 1);
    chk("hit_score_lit", 32'(score), 1);
    chk("hit_clears",    32'(mole_oh), 0);
    key = 8'h00;

    // New mole appears on the next tick, in a different hole.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc();
      if (mole_oh != 8'h00) found = 1'b1;
    end
    chk("respawn_seen", 32'(found), 1);
    chk("respawn_moved", 32'(mole_oh != hole_bits(old_idx)), 1);

    // No keys: a timeout every MOLE_TICKS ticks (12 clocks).
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (miss_pulse) found = 1'b1;
    end
    chk("timeout_seen", 32'(found), 1);
    gap = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      gap++;
      if (miss_pulse) found = 1'b1;
    end
    chk("timeout_gap", 32'(gap), 12);
    chk("timeout_score", 32'(score), 1);

    // All keys at once with a mole up: hit and miss together.
    key = 8'hFF;
    cyc();
    chk("all_keys_hit",   32'(hit_pulse), 1);
    chk("all_keys_miss",  32'(miss_pulse), 1);
    chk("all_keys_score", 32'(score), 2);
    cycles(4);
    chk("held_no_hit",  32'(hit_pulse), 0);
    chk("held_no_miss", 32'(miss_pulse), 0);

    // Wrong key only.
    key = 8'h00;
    cyc();
    key = (m_mole >= 0) ? hole_bits((m_mole + 1) % 8) : 8'h01;
    cyc();
    chk("wrong_miss",  32'(miss_pulse), 1);
    chk("wrong_nohit", 32'(hit_pulse), 0);
    chk("wrong_score", 32'(score), 2);
    key = 8'h00;

    // Run the game out.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (game_state == 2'b10) found = 1'b1;
    end
    chk("over_reached", 32'(found), 1);
    chk("over_time",  32'(time_left), 0);
    chk("over_mole",  32'(mole_oh), 0);
    chk("over_score", 32'(score), 2);

    // Keys in OVER do nothing.
    key = 8'h01;
    cyc();
    chk("over_key_hit",  32'(hit_pulse), 0);
    chk("over_key_miss", 32'(miss_pulse), 0);
    key = 8'h00;
    cyc();

    // Restart from OVER.
    start = 1'b1;
    cyc();
    chk("restart_state", 32'(game_state), 1);
    chk("restart_score", 32'(score), 0);
    chk("restart_time",  32'(time_left), 20);
    start = 1'b0;
    cycles(3);

    // Reset mid-game with start and key held high.
    start = 1'b1;
    key = 8'hFF;
    cycles(2);
    rst = 1'b1;
    cyc();
    chk("rst_state", 32'(game_state), 0);
    chk("rst_mole",  32'(mole_oh), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_time",  32'(time_left), 0);
    chk("rst_hit",   32'(hit_pulse), 0);
    chk("rst_miss",  32'(miss_pulse), 0);
    rst = 1'b0;
    cycles(5);
    chk("held_start_idle", 32'(game_state), 0);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk("post_rst_play", 32'(game_state), 1);
    chk("post_rst_time", 32'(time_left), 20);
    start = 1'b0;
    key = 8'h00;
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
